// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared sizes, state encoding and index helpers for the round-robin arbiter
package noc_arb_pkg;
  localparam int NUM_REQ = 5;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, GRANTED} state_e;
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick_5.sv
// rr_pick_5: combinational round-robin pick of the first set request at or after ptr
module rr_pick_5 import noc_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               found
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0] pos, sel;
  logic [IDX_W:0] sum;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    pos = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) if (rot[k]) pos = IDX_W'(k);
    sum = {1'b0, ptr} + {1'b0, pos};
    sel = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
    found = |req;
    pick = found ? NUM_REQ'(1) << sel : '0;
  end
endmodule

// File: rtl/rr_arbiter_5.sv
// rr_arbiter_5: registered 5-way round-robin arbiter with optional grant locking
module rr_arbiter_5 import noc_arb_pkg::*; #(
  parameter bit LOCK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               lock_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic found, keep;
  // a release moves the pointer past the holder before the same-cycle re-arbitration
  always_comb begin
    keep = (state_q == GRANTED) && LOCK_EN && lock_i && |(req_i & grant_q);
    ptr_d = (state_q == GRANTED && !keep) ? next_ptr(onehot_to_idx(grant_q)) : ptr_q;
  end
  rr_pick_5 u_pick (
    .req   (req_i),
    .ptr   (ptr_d),
    .pick  (pick),
    .found (found)
  );
  always_comb begin
    grant_d = keep ? grant_q : pick;
    state_d = (keep || found) ? GRANTED : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
    end
  end
  assign grant_o = grant_q;
  assign grant_valid_o = |grant_q;
  assign grant_idx_o = onehot_to_idx(grant_q);
endmodule

// File: tb/tb_rr_arbiter_5.sv
// tb_rr_arbiter_5: directed vector table plus randomized run against a round-robin reference model
module tb_rr_arbiter_5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] req_i = '0;
  logic lock_i = 1'b0;
  logic [4:0] g1, g0;
  logic v1, v0;
  logic [2:0] i1, i0;
  int tests = 0;
  int fails = 0;
  int ptr_m [2];
  int hold_m [2];
  int wt [2][5];

  always #5 clk = ~clk;

  rr_arbiter_5 #(.LOCK_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i),
    .grant_o(g1), .grant_valid_o(v1), .grant_idx_o(i1)
  );
  rr_arbiter_5 #(.LOCK_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i),
    .grant_o(g0), .grant_valid_o(v0), .grant_idx_o(i0)
  );

  typedef struct {
    logic       r;
    logic [4:0] rq;
    logic       lk;
    logic [4:0] e1;
    logic [4:0] e0;
  } vec_t;

  function automatic logic [2:0] enc(input logic [4:0] g);
    for (int i = 0; i < 5; i++) if (g[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic chk(input string name, input logic [4:0] g, input logic v,
                     input logic [2:0] ix, input logic [4:0] exp);
    tests++;
    if (g !== exp || v !== (|exp) || ix !== enc(exp) || !$onehot0(g)) begin
      fails++;
      $display("FAIL %s: grant=%b valid=%b idx=%0d, expected grant=%b valid=%b idx=%0d",
               name, g, v, ix, exp, |exp, enc(exp));
    end
  endtask

  // reference: holder keeps grant only when locking is allowed and it still requests;
  // any release hands priority to the requester just after the holder
  task automatic model_step(input int m, input logic r, input logic [4:0] rq, input logic lk);
    if (r) begin
      ptr_m[m] = 0;
      hold_m[m] = -1;
      return;
    end
    if (hold_m[m] >= 0 && m == 1 && lk && rq[hold_m[m]]) return;
    if (hold_m[m] >= 0) ptr_m[m] = (hold_m[m] + 1) % 5;
    hold_m[m] = -1;
    for (int k = 0; k < 5; k++)
      if (rq[(ptr_m[m] + k) % 5]) begin
        hold_m[m] = (ptr_m[m] + k) % 5;
        break;
      end
  endtask

  function automatic logic [4:0] model_grant(input int m);
    return (hold_m[m] < 0) ? 5'd0 : 5'(1) << hold_m[m];
  endfunction

  task automatic cyc(input logic r, input logic [4:0] rq, input logic lk);
    rst = r;
    req_i = rq;
    lock_i = lk;
    @(posedge clk);
    model_step(1, r, rq, lk);
    model_step(0, r, rq, lk);
    @(negedge clk);
  endtask

  task automatic fair(input int m, input logic [4:0] g, input logic [4:0] pg, input logic [4:0] rq);
    logic ev;
    ev = (g != 5'd0) && (g != pg);
    for (int i = 0; i < 5; i++)
      if (!rq[i] || g[i]) wt[m][i] = 0;
      else if (ev) wt[m][i]++;
    if (ev) begin
      tests++;
      for (int i = 0; i < 5; i++)
        if (wt[m][i] >= 5) begin
          fails++;
          $display("FAIL fairness lock_en=%0d: requester %0d waited %0d grants, required < 5", m, i, wt[m][i]);
          break;
        end
    end
  endtask

  vec_t vt [25];
  logic [4:0] rq, pg1, pg0;
  logic lk;

  initial begin
    vt = '{
      '{1'b1, 5'b11111, 1'b1, 5'b00000, 5'b00000},
      '{1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000},
      '{1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000},
      '{1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000},
      '{1'b0, 5'b10100, 1'b0, 5'b00100, 5'b00100},
      '{1'b0, 5'b10100, 1'b0, 5'b10000, 5'b10000},
      '{1'b0, 5'b10100, 1'b0, 5'b00100, 5'b00100},
      '{1'b0, 5'b10100, 1'b0, 5'b10000, 5'b10000},
      '{1'b1, 5'b11111, 1'b1, 5'b00000, 5'b00000},
      '{1'b0, 5'b11111, 1'b1, 5'b00001, 5'b00001},
      '{1'b0, 5'b11111, 1'b1, 5'b00001, 5'b00010},
      '{1'b0, 5'b11111, 1'b1, 5'b00001, 5'b00100},
      '{1'b0, 5'b11111, 1'b1, 5'b00001, 5'b01000},
      '{1'b0, 5'b11111, 1'b0, 5'b00010, 5'b10000},
      '{1'b1, 5'b00000, 1'b0, 5'b00000, 5'b00000},
      '{1'b0, 5'b01000, 1'b1, 5'b01000, 5'b01000},
      '{1'b0, 5'b00001, 1'b1, 5'b00001, 5'b00001},
      '{1'b0, 5'b01000, 1'b1, 5'b01000, 5'b01000},
      '{1'b1, 5'b01000, 1'b1, 5'b00000, 5'b00000},
      '{1'b0, 5'b00010, 1'b0, 5'b00010, 5'b00010},
      '{1'b0, 5'b00010, 1'b1, 5'b00010, 5'b00010},
      '{1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000},
      '{1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000},
      '{1'b0, 5'b10001, 1'b0, 5'b10000, 5'b10000},
      '{1'b0, 5'b10001, 1'b0, 5'b00001, 5'b00001}
    };
    @(negedge clk);
    for (int n = 0; n < 25; n++) begin
      cyc(vt[n].r, vt[n].rq, vt[n].lk);
      chk($sformatf("vec%0d_lock1", n), g1, v1, i1, vt[n].e1);
      chk($sformatf("vec%0d_lock0", n), g0, v0, i0, vt[n].e0);
    end
    // multi-cycle: lock released with holder still requesting, then reset mid-grant
    cyc(1'b1, 5'b00000, 1'b0);
    cyc(1'b0, 5'b00110, 1'b1);
    chk("seq_first", g1, v1, i1, 5'b00010);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 5'b00110, 1'b1);
      chk("seq_hold", g1, v1, i1, 5'b00010);
    end
    cyc(1'b0, 5'b00110, 1'b0);
    chk("seq_release", g1, v1, i1, 5'b00100);
    cyc(1'b1, 5'b00110, 1'b1);
    chk("seq_rst", g1, v1, i1, 5'b00000);
    cyc(1'b0, 5'b00110, 1'b0);
    chk("seq_after_rst", g1, v1, i1, 5'b00010);
    cyc(1'b1, 5'b00000, 1'b0);
    for (int m = 0; m < 2; m++) for (int i = 0; i < 5; i++) wt[m][i] = 0;
    rq = 5'd0;
    pg1 = 5'd0;
    pg0 = 5'd0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 5; i++) if ($urandom_range(5, 0) == 0) rq[i] = ~rq[i];
      lk = ($urandom_range(3, 0) != 0);
      cyc(1'b0, rq, lk);
      chk("rand_lock1", g1, v1, i1, model_grant(1));
      chk("rand_lock0", g0, v0, i0, model_grant(0));
      fair(1, g1, pg1, rq);
      fair(0, g0, pg0, rq);
      pg1 = g1;
      pg0 = g0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_5.md
RR_ARBITER_5 -- requirements
Module: rr_arbiter_5

Interface
REQ-001 SHALL have parameter LOCK_EN, default 1, meaning: 1 = holder keeps its grant while lock_i is high; 0 = re-arbitrate every cycle.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_i  input  5  per-requester request bits, index 0..4.
REQ-005 SHALL have port lock_i  input  1  current holder requests to keep its grant (packet in progress).
REQ-006 SHALL have port grant_o  output  5  registered grant, one-hot or all-zero, directly usable as a 5-way one-hot mux select.
REQ-007 SHALL have port grant_valid_o  output  1  high when grant_o is non-zero.
REQ-008 SHALL have port grant_idx_o  output  3  binary index of the granted bit, 0 when grant_valid_o is low.

Function
REQ-009 SHALL keep a priority pointer ptr (0..4) naming the highest-priority requester; the search order is ptr, ptr+1, ... modulo 5.
REQ-010 SHALL have two states: IDLE (grant_o = 0) and GRANTED (grant_o one-hot).
REQ-011 SHALL register every grant: a request seen in cycle N produces a grant in cycle N+1, with no combinational path from req_i to grant_o.
REQ-012 In IDLE with req_i = 0, SHALL stay in IDLE with outputs zero.
REQ-013 In IDLE with req_i != 0, SHALL grant the first set bit in search order and enter GRANTED; ptr is unchanged.
REQ-014 In GRANTED with LOCK_EN=1, lock_i=1 and req_i[idx]=1, SHALL hold the same grant, and ptr is unchanged.
REQ-015 A release occurs in any other GRANTED case: lock_i=0, holder request dropped, or LOCK_EN=0.
REQ-016 On release, SHALL set ptr to (idx+1) mod 5, with index 4 wrapping to 0.
REQ-017 On release, SHALL arbitrate in the same cycle over req_i using the new ptr, so the releasing holder has lowest priority.
REQ-018 After a release, SHALL enter GRANTED if any request is pending, otherwise IDLE.
REQ-019 Back-to-back grants SHALL occur with zero idle cycles.
REQ-020 SHALL never assert more than one grant_o bit; grant_valid_o SHALL equal |grant_o; grant_idx_o SHALL equal the encoding of grant_o.
REQ-021 When a locked holder drops its request, SHALL treat it as a release even if lock_i is still high.

Reset
REQ-022 While rst is high at a clock edge, SHALL force grant_o=0, grant_valid_o=0, grant_idx_o=0, ptr=0 and state IDLE, regardless of req_i and lock_i.
REQ-023 Reset during GRANTED SHALL drop the grant in the next cycle; no pointer history survives reset.
REQ-024 In the first cycle after rst deasserts, SHALL arbitrate normally from ptr=0.

Structure
REQ-025 Shared package noc_arb_pkg SHALL hold NUM_REQ=5, IDX_W=3, the state enum {IDLE, GRANTED}, and a one-hot-to-index function.
REQ-026 SHALL instantiate one combinational sub-module, rr_pick_5, which takes (req, ptr) and returns the one-hot pick and a found flag.
REQ-027 The registered state, ptr and outputs SHALL live in rr_arbiter_5.

Verification
REQ-028 Reset, then req_i=00000 for 3 cycles -> grant_o=00000, grant_valid_o=0, grant_idx_o=0 every cycle.
REQ-029 LOCK_EN=1, lock_i=0, req_i=10100 held -> grants 00100 (idx 2), 10000 (idx 4), 00100, 10000, ... on consecutive cycles.
REQ-030 req_i=11111, lock_i=1 for 4 cycles, then lock_i=0 -> 00001 for 4 cycles, then 00010 in the cycle after lock_i falls.
REQ-031 Holder idx 3 locked, req_i changes to 00001 -> next cycle grant 00001 (ptr=4, bit 4 clear, wraps to 0).
REQ-032 rst pulsed for 1 cycle while 01000 is granted, then req_i=00010 -> zeros for one cycle, then 00010.
REQ-033 Random req_i/lock_i for 10k cycles, LOCK_EN in {0,1} -> grant_o always one-hot or zero; each persistent requester is granted within 5 grants.
